// File: rtl/lfsr_seq_checker.sv
// lfsr_seq_checker: hunts, verifies and locks onto the 4-bit {q3^q2, q3:1} generator sequence,
// flags/counts mismatches while locked; optional period measure via LFSR_SEQ_CHK_PERIOD_EN.
module lfsr_seq_checker #(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             aset,
  input  logic             ena,
  input  logic [3:0]       din,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             stuck,
  output logic [7:0]       period,
  output logic [1:0]       dbg_state_o
);

  // Handshake: ena qualifies din for exactly one cycle; there is no ready, every ena=1 cycle is consumed.
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } state_e;

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(LOSS_CNT + 1);
  localparam logic [GOOD_W-1:0] GOOD_TGT = GOOD_W'(LOCK_CNT);
  localparam logic [MISS_W-1:0] MISS_TGT = MISS_W'(LOSS_CNT);

  state_e             state_q, state_d;
  logic [3:0]         last_q, last_d;
  logic [GOOD_W-1:0]  good_q, good_d, good_inc;
  logic [MISS_W-1:0]  miss_q, miss_d, miss_inc;
  logic               err_q, err_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               stuck_q, stuck_d;
  logic [3:0]         pred;

  always_ff @(posedge clk) begin
    if (aset) begin
      state_q   <= HUNT;
      last_q    <= 4'd0;
      good_q    <= '0;
      miss_q    <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      stuck_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      good_q    <= good_d;
      miss_q    <= miss_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      stuck_q   <= stuck_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    good_d    = good_q;
    miss_d    = miss_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    stuck_d   = stuck_q;
    pred      = {last_q[3] ^ last_q[2], last_q[3:1]};
    good_inc  = good_q + 1'b1;
    miss_inc  = miss_q + 1'b1;
    if (ena) begin
      stuck_d = (din == 4'd0);
      case (state_q)
        HUNT: begin
          if (din != 4'd0) begin
            last_d  = din;
            good_d  = '0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (din == pred) begin
            good_d = good_inc;
            last_d = din;
            if (good_inc == GOOD_TGT) begin
              state_d = LOCK;
              miss_d  = '0;
            end
          end else begin
            last_d = din;
            good_d = '0;
            if (din == 4'd0) state_d = HUNT;
          end
        end
        LOCK: begin
          if (din == pred) begin
            last_d = din;
            miss_d = '0;
          end else begin
            // Flywheel: keep following the prediction so one corrupted word costs one error.
            err_d  = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            last_d = pred;
            miss_d = miss_inc;
            if (miss_inc == MISS_TGT) begin
              state_d = HUNT;
              good_d  = '0;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end else if (state_q != HUNT && state_q != VERIFY && state_q != LOCK) begin
      state_d = HUNT;
    end
  end

`ifdef LFSR_SEQ_CHK_PERIOD_EN
  logic       lock_entry;
  logic [3:0] ref_word_q, ref_word_d;
  logic [7:0] pcnt_q, pcnt_d, pcnt_sat;
  logic [7:0] period_q, period_d;

  assign lock_entry = ena & (state_q == VERIFY) & (state_d == LOCK);

  always_comb begin
    ref_word_d = ref_word_q;
    pcnt_d     = pcnt_q;
    period_d   = period_q;
    pcnt_sat   = (pcnt_q == 8'hFF) ? 8'hFF : pcnt_q + 8'd1;
    if (lock_entry) begin
      ref_word_d = din;
      pcnt_d     = 8'd0;
    end else if (ena && state_q == LOCK) begin
      if (din == ref_word_q) begin
        period_d = pcnt_sat;
        pcnt_d   = 8'd0;
      end else begin
        pcnt_d = pcnt_sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (aset) begin
      ref_word_q <= 4'd0;
      pcnt_q     <= 8'd0;
      period_q   <= 8'd0;
    end else begin
      ref_word_q <= ref_word_d;
      pcnt_q     <= pcnt_d;
      period_q   <= period_d;
    end
  end

  assign period = period_q;
`else
  assign period = 8'd0;
`endif

  assign locked      = (state_q == LOCK);
  assign err         = err_q;
  assign err_cnt     = err_cnt_q;
  assign stuck       = stuck_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Bench for lfsr_seq_checker: directed scenarios plus random traffic against a behavioural model.
module tb_lfsr_seq_checker;
  localparam int LOCK_CNT = 3;
  localparam int LOSS_CNT = 2;
  localparam int ERR_W    = 8;
  localparam int W        = 13 + ERR_W;
  localparam int ERR_MAX  = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             aset = 1'b1;
  logic             ena = 1'b0;
  logic [3:0]       din = 4'd0;
  logic             locked, err, stuck;
  logic [ERR_W-1:0] err_cnt;
  logic [7:0]       period;
  logic [1:0]       dbg_state;

  lfsr_seq_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(ERR_W)) dut (
    .clk(clk), .aset(aset), .ena(ena), .din(din),
    .locked(locked), .err(err), .err_cnt(err_cnt), .stuck(stuck),
    .period(period), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  // behavioural model: phase 0=hunting, 1=verifying, 2=locked
  int         m_phase, m_good, m_miss, m_errc, m_per, m_cnt;
  bit         m_err, m_stuck;
  logic [3:0] m_last, m_ref;

  function automatic logic [3:0] nxt(input logic [3:0] v);
    return {v[3] ^ v[2], v[3:1]};
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_good = 0; m_miss = 0; m_errc = 0; m_per = 0; m_cnt = 0;
    m_err = 0; m_stuck = 0; m_last = 4'd0; m_ref = 4'd0;
  endtask

  task automatic model_step(input bit a, input bit e, input logic [3:0] d);
    logic [3:0] p;
    m_err = 0;
    if (a) begin
      model_reset();
    end else if (e) begin
      p = nxt(m_last);
      m_stuck = (d == 4'd0);
      if (m_phase == 2) begin
`ifdef LFSR_SEQ_CHK_PERIOD_EN
        if (d == m_ref) begin
          m_per = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
          m_cnt = 0;
        end else begin
          m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
        end
`endif
        if (d == p) begin
          m_last = d; m_miss = 0;
        end else begin
          m_err = 1;
          if (m_errc < ERR_MAX) m_errc++;
          m_last = p;
          m_miss++;
          if (m_miss == LOSS_CNT) begin m_phase = 0; m_good = 0; end
        end
      end else if (m_phase == 1) begin
        if (d == p) begin
          m_good++; m_last = d;
          if (m_good == LOCK_CNT) begin
            m_phase = 2; m_miss = 0; m_ref = d; m_cnt = 0;
          end
        end else begin
          m_last = d; m_good = 0;
          if (d == 4'd0) m_phase = 0;
        end
      end else if (d != 4'd0) begin
        m_last = d; m_good = 0; m_phase = 1;
      end
    end
  endtask

  function automatic logic [W-1:0] model_vec();
`ifdef LFSR_SEQ_CHK_PERIOD_EN
    return {2'(m_phase), (m_phase == 2), m_err, ERR_W'(m_errc), m_stuck, 8'(m_per)};
`else
    return {2'(m_phase), (m_phase == 2), m_err, ERR_W'(m_errc), m_stuck, 8'd0};
`endif
  endfunction

  // driver: apply one cycle, then record what the model says the outputs must be
  task automatic cycle(input bit a, input bit e, input logic [3:0] d);
    aset = a; ena = e; din = d;
    @(posedge clk);
    #1;
    model_step(a, e, d);
    exp_q.push_back(model_vec());
  endtask

  task automatic samp(input logic [3:0] d);
    cycle(1'b0, 1'b1, d);
  endtask

  task automatic lock_on();
    samp(4'b1000); samp(4'b1100); samp(4'b0110); samp(4'b1011);
  endtask

  task automatic isolated_error();
    samp(nxt(m_last) ^ 4'b0100);
    samp(nxt(m_last));
  endtask

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    logic [W-1:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {dbg_state, locked, err, err_cnt, stuck, period};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL outputs @%0t: got st=%0d lk=%0b err=%0b cnt=%0d stk=%0b per=%0d expected st=%0d lk=%0b err=%0b cnt=%0d stk=%0b per=%0d",
                 $time, a[W-1:W-2], a[W-3], a[W-4], a[W-5:9], a[8], a[7:0],
                 e[W-1:W-2], e[W-3], e[W-4], e[W-5:9], e[8], e[7:0]);
      end
    end
  end

  initial begin
    logic [3:0] gen;
    model_reset();
    // reset state
    cycle(1'b1, 1'b0, 4'd0);
    chk("reset_locked", locked, 0);
    chk("reset_err_cnt", err_cnt, 0);
    chk("reset_stuck", stuck, 0);
    chk("reset_period", period, 0);

    // acquire lock
    lock_on();
    chk("s1_locked", locked, 1);
    chk("s1_err_cnt", err_cnt, 0);

    // isolated bad word while locked
    samp(4'b1111);
    chk("s2_err_pulse", err, 1);
    samp(4'b0110);
    chk("s2_err_clear", err, 0);
    chk("s2_err_cnt", err_cnt, 1);
    chk("s2_locked", locked, 1);

    // two misses drop lock
    samp(4'b0000);
    chk("s3_err1", err, 1);
    chk("s3_stuck", stuck, 1);
    chk("s3_locked_hold", locked, 1);
    samp(4'b0000);
    chk("s3_err2", err, 1);
    chk("s3_lost", locked, 0);
    chk("s3_err_cnt", err_cnt, 3);
    samp(4'b0000);
    chk("s3_hunt_state", dbg_state, 0);
    chk("s3_no_err", err, 0);

    // ena toggled every cycle
    cycle(1'b1, 1'b0, 4'd0);
    cycle(1'b0, 1'b1, 4'b1000); cycle(1'b0, 1'b0, 4'($urandom_range(0, 15)));
    cycle(1'b0, 1'b1, 4'b1100); cycle(1'b0, 1'b0, 4'($urandom_range(0, 15)));
    cycle(1'b0, 1'b1, 4'b0110); cycle(1'b0, 1'b0, 4'($urandom_range(0, 15)));
    cycle(1'b0, 1'b1, 4'b1011);
    chk("s4_locked", locked, 1);
    cycle(1'b0, 1'b0, 4'b0000);
    chk("s4_locked_frozen", locked, 1);
    chk("s4_stuck_frozen", stuck, 0);

    // reset while locked with err_cnt=5
    for (int i = 0; i < 5; i++) isolated_error();
    chk("s5_err_cnt5", err_cnt, 5);
    chk("s5_locked", locked, 1);
    cycle(1'b1, 1'b1, 4'b0000);
    chk("s5_locked", locked, 0);
    chk("s5_err_cnt", err_cnt, 0);
    chk("s5_stuck", stuck, 0);
    chk("s5_period", period, 0);

    // period measurement and counter saturation
    lock_on();
    samp(4'b1101); samp(4'b0110); samp(4'b1011);
`ifdef LFSR_SEQ_CHK_PERIOD_EN
    chk("s6_period", period, 3);
`else
    chk("s6_period_off", period, 0);
`endif
    for (int i = 0; i < ERR_MAX + 4; i++) isolated_error();
    chk("sat_err_cnt", err_cnt, ERR_MAX);
    chk("sat_locked", locked, 1);

    // random traffic: mostly the true sequence, with corruption, idle cycles and resets
    gen = 4'b1000;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        cycle(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end else if ($urandom_range(0, 3) == 0) begin
        cycle(1'b0, 1'b0, 4'($urandom_range(0, 15)));
      end else begin
        gen = nxt(gen);
        if (gen == 4'd0 && $urandom_range(0, 3) == 0) gen = 4'($urandom_range(1, 15));
        if ($urandom_range(0, 9) < 8) samp(gen);
        else samp(4'($urandom_range(0, 15)));
      end
    end

    aset = 1'b0; ena = 1'b0;
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
